// File: rtl/tini_cpu_core_pkg.sv
// Shared definitions for the tini_cpu_core multi-cycle NDS32-subset core:
// opcode/sub-op encodings, FSM states and immediate helpers.
package tini_cpu_core_pkg;

   localparam logic [5:0] OP_ALU1 = 6'b100000;
   localparam logic [5:0] OP_ADDI = 6'b101000;
   localparam logic [5:0] OP_ORI  = 6'b101100;
   localparam logic [5:0] OP_XORI = 6'b101011;
   localparam logic [5:0] OP_MOVI = 6'b100010;
   localparam logic [5:0] OP_LWI  = 6'b000010;
   localparam logic [5:0] OP_SWI  = 6'b001010;
   localparam logic [5:0] OP_MEM  = 6'b011100;

   localparam logic [4:0] SUB_ADD   = 5'b00000;
   localparam logic [4:0] SUB_SUB   = 5'b00001;
   localparam logic [4:0] SUB_AND   = 5'b00010;
   localparam logic [4:0] SUB_XOR   = 5'b00011;
   localparam logic [4:0] SUB_OR    = 5'b00100;
   localparam logic [4:0] SUB_SLLI  = 5'b01000;
   localparam logic [4:0] SUB_SRLI  = 5'b01001;
   localparam logic [4:0] SUB_ROTRI = 5'b01011;

   localparam logic [7:0] MSUB_LW = 8'h02;
   localparam logic [7:0] MSUB_SW = 8'h0A;

   typedef enum logic [2:0] {
      S_IF0,
      S_IF1,
      S_ID,
      S_EX,
      S_MEM,
      S_WB
   } state_t;

   function automatic logic [31:0] sext15(input logic [14:0] v);
      return {{17{v[14]}}, v};
   endfunction

   function automatic logic [31:0] sext20(input logic [19:0] v);
      return {{12{v[19]}}, v};
   endfunction

endpackage

// File: rtl/tini_cpu_core_regfile.sv
// 32x32 register file: three asynchronous read ports (ra, rb, rt),
// one synchronous write port and a synchronous active-low clear.
module tini_regfile
   import tini_cpu_core_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ra_addr,
   input  logic [4:0]  rb_addr,
   input  logic [4:0]  rt_addr,
   output logic [31:0] ra_data,
   output logic [31:0] rb_data,
   output logic [31:0] rt_data,
   input  logic        we,
   input  logic [4:0]  w_addr,
   input  logic [31:0] w_data
);

   logic [31:0] regs [32];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
      end else if (we) begin
         regs[w_addr] <= w_data;
      end
   end

   assign ra_data = regs[ra_addr];
   assign rb_data = regs[rb_addr];
   assign rt_data = regs[rt_addr];

endmodule

// File: rtl/tini_cpu_core.sv
// Multi-cycle 32-bit NDS32-subset core: fixed six-state FSM
// (IF0, IF1, ID, EX, MEM, WB), inline ALU, external word memories.
module tini_cpu_core
   import tini_cpu_core_pkg::*;
#(
   parameter int          PC_W   = 10,
   parameter int          DA_W   = 12,
   parameter int unsigned RST_PC = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     instruction,
   output logic            alu_overflow,
   output logic            IM_read,
   output logic            IM_write,
   output logic            IM_enable,
   output logic [PC_W-1:0] IM_address,
   output logic            DM_read,
   output logic            DM_write,
   output logic            DM_enable,
   output logic [DA_W-1:0] DM_address,
   output logic [31:0]     DM_in,
   input  logic [31:0]     DM_out
);

   state_t            state;
   logic [PC_W-1:0]   pc;
   logic [31:0]       ir;
   logic [31:0]       res_q;
   logic              wr_q, ld_q, im_on;
   logic              dm_en_q, dm_rd_q, dm_wr_q;

   logic [31:0]       ra_data, rb_data, rt_data;
   logic [31:0]       sum, diff, addi_sum;
   logic [63:0]       rot;

   logic [31:0]       ex_res;
   logic [DA_W-1:0]   ex_ea;
   logic              ex_wr, ex_ld, ex_st, ex_ovf_upd, ex_ovf;

   tini_regfile u_rf (
      .clk     (clk),
      .rst     (rst),
      .ra_addr (ir[19:15]),
      .rb_addr (ir[14:10]),
      .rt_addr (ir[24:20]),
      .ra_data (ra_data),
      .rb_data (rb_data),
      .rt_data (rt_data),
      .we      ((state == S_WB) && wr_q),
      .w_addr  (ir[24:20]),
      .w_data  (ld_q ? DM_out : res_q)
   );

   assign sum      = ra_data + rb_data;
   assign diff     = ra_data - rb_data;
   assign addi_sum = ra_data + sext15(ir[14:0]);
   assign rot      = {ra_data, ra_data} >> ir[14:10];

   always_comb begin
      ex_res     = '0;
      ex_ea      = '0;
      ex_wr      = 1'b0;
      ex_ld      = 1'b0;
      ex_st      = 1'b0;
      ex_ovf_upd = 1'b0;
      ex_ovf     = 1'b0;
      if (!ir[31]) begin
         unique case (ir[30:25])
            OP_ALU1: begin
               ex_wr = 1'b1;
               unique case (ir[4:0])
                  SUB_ADD: begin
                     ex_res     = sum;
                     ex_ovf_upd = 1'b1;
                     ex_ovf     = (ra_data[31] == rb_data[31]) && (sum[31] != ra_data[31]);
                  end
                  SUB_SUB: begin
                     ex_res     = diff;
                     ex_ovf_upd = 1'b1;
                     ex_ovf     = (ra_data[31] != rb_data[31]) && (diff[31] != ra_data[31]);
                  end
                  SUB_AND:   ex_res = ra_data & rb_data;
                  SUB_XOR:   ex_res = ra_data ^ rb_data;
                  SUB_OR:    ex_res = ra_data | rb_data;
                  SUB_SLLI:  ex_res = ra_data << ir[14:10];
                  SUB_SRLI:  ex_res = ra_data >> ir[14:10];
                  SUB_ROTRI: ex_res = rot[31:0];
                  default:   ex_wr  = 1'b0;
               endcase
            end
            OP_ADDI: begin
               ex_wr      = 1'b1;
               ex_res     = addi_sum;
               ex_ovf_upd = 1'b1;
               ex_ovf     = (ra_data[31] == ir[14]) && (addi_sum[31] != ra_data[31]);
            end
            OP_ORI: begin
               ex_wr  = 1'b1;
               ex_res = ra_data | {17'b0, ir[14:0]};
            end
            OP_XORI: begin
               ex_wr  = 1'b1;
               ex_res = ra_data ^ {17'b0, ir[14:0]};
            end
            OP_MOVI: begin
               ex_wr  = 1'b1;
               ex_res = sext20(ir[19:0]);
            end
            // Only the low DA_W bits of the address survive, so the
            // scaled immediate is added at that width directly.
            OP_LWI, OP_SWI: begin
               ex_ea = ra_data[DA_W-1:0] + {ir[DA_W-3:0], 2'b00};
               ex_ld = (ir[30:25] == OP_LWI);
               ex_st = (ir[30:25] == OP_SWI);
               ex_wr = ex_ld;
            end
            OP_MEM: begin
               ex_ea = ra_data[DA_W-1:0] + DA_W'(rb_data << ir[9:8]);
               ex_ld = (ir[7:0] == MSUB_LW);
               ex_st = (ir[7:0] == MSUB_SW);
               ex_wr = ex_ld;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= S_IF0;
         pc           <= PC_W'(RST_PC);
         ir           <= '0;
         res_q        <= '0;
         wr_q         <= 1'b0;
         ld_q         <= 1'b0;
         im_on        <= 1'b0;
         dm_en_q      <= 1'b0;
         dm_rd_q      <= 1'b0;
         dm_wr_q      <= 1'b0;
         DM_address   <= '0;
         DM_in        <= '0;
         alu_overflow <= 1'b0;
      end else begin
         unique case (state)
            S_IF0: begin
               state <= S_IF1;
               im_on <= 1'b1;
            end
            S_IF1: begin
               state <= S_ID;
               im_on <= 1'b0;
            end
            S_ID: begin
               state <= S_EX;
               ir    <= instruction;
            end
            S_EX: begin
               state      <= S_MEM;
               res_q      <= ex_res;
               wr_q       <= ex_wr;
               ld_q       <= ex_ld;
               DM_address <= ex_ea;
               dm_en_q    <= ex_ld | ex_st;
               dm_rd_q    <= ex_ld;
               dm_wr_q    <= ex_st;
               if (ex_st) DM_in <= rt_data;
               if (ex_ovf_upd) alu_overflow <= ex_ovf;
            end
            S_MEM: begin
               state   <= S_WB;
               dm_en_q <= 1'b0;
               dm_rd_q <= 1'b0;
               dm_wr_q <= 1'b0;
            end
            S_WB: begin
               state <= S_IF0;
               pc    <= pc + PC_W'(4);
               im_on <= 1'b1;
            end
            default: state <= S_IF0;
         endcase
      end
   end

   assign IM_address = pc;
   assign IM_read    = im_on;
   assign IM_enable  = im_on;
   assign IM_write   = 1'b0;
   // Gated by rst so a reset landing on S_MEM never commits the access.
   assign DM_enable  = dm_en_q & rst;
   assign DM_read    = dm_rd_q & rst;
   assign DM_write   = dm_wr_q & rst;

endmodule

// File: tb/tb_tini_cpu_core.sv
// Self-checking bench for tini_cpu_core: directed prologue plus random
// program, compared against an instruction-level reference model.
module tb_tini_cpu_core;

   localparam int NI = 300;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] instruction;
   logic        alu_overflow;
   logic        IM_read, IM_write, IM_enable;
   logic [9:0]  IM_address;
   logic        DM_read, DM_write, DM_enable;
   logic [11:0] DM_address;
   logic [31:0] DM_in;
   logic [31:0] DM_out;

   tini_cpu_core #(.PC_W(10), .DA_W(12), .RST_PC(0)) dut (
      .clk          (clk),
      .rst          (rst),
      .instruction  (instruction),
      .alu_overflow (alu_overflow),
      .IM_read      (IM_read),
      .IM_write     (IM_write),
      .IM_enable    (IM_enable),
      .IM_address   (IM_address),
      .DM_read      (DM_read),
      .DM_write     (DM_write),
      .DM_enable    (DM_enable),
      .DM_address   (DM_address),
      .DM_in        (DM_in),
      .DM_out       (DM_out)
   );

   always #5 clk = ~clk;

   logic [31:0] imem [256];
   logic [31:0] dmem [1024];
   logic        mem_init = 1'b1;

   function automatic logic [31:0] seed_word(input int unsigned i);
      return (i * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   always @(posedge clk) begin
      if (IM_enable && IM_read) instruction <= imem[IM_address[9:2]];
   end

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 1024; i++) dmem[i] <= seed_word(i);
      end else if (DM_enable) begin
         if (DM_write) dmem[DM_address[11:2]] <= DM_in;
         if (DM_read)  DM_out <= dmem[DM_address[11:2]];
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference model state
   logic [31:0] m_reg [32];
   logic [31:0] m_mem [1024];
   logic [9:0]  m_pc;
   logic        m_ovf;
   logic        exp_ld, exp_st;
   logic [11:0] exp_addr;
   logic [31:0] exp_din;

   function automatic logic [31:0] enc_alu(input int rt, input int ra, input int rb, input int sub);
      return {1'b0, 6'b100000, 5'(rt), 5'(ra), 5'(rb), 5'd0, 5'(sub)};
   endfunction
   function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int ra, input int imm);
      return {1'b0, op, 5'(rt), 5'(ra), 15'(imm)};
   endfunction
   function automatic logic [31:0] enc_movi(input int rt, input int imm);
      return {1'b0, 6'b100010, 5'(rt), 20'(imm)};
   endfunction
   function automatic logic [31:0] enc_mem(input int rt, input int ra, input int rb, input int sv, input int sub8);
      return {1'b0, 6'b011100, 5'(rt), 5'(ra), 5'(rb), 2'(sv), 8'(sub8)};
   endfunction

   function automatic logic [31:0] rand_instr();
      int    k;
      int    subs [8] = '{0, 1, 2, 3, 4, 8, 9, 11};
      int    rt, ra, rb;
      rt = $urandom_range(0, 31);
      ra = $urandom_range(0, 31);
      rb = $urandom_range(0, 31);
      k  = $urandom_range(0, 11);
      case (k)
         0:       return enc_alu(rt, ra, rb, subs[$urandom_range(0, 7)]);
         1:       return enc_alu(rt, ra, rb, $urandom_range(0, 31));
         2:       return enc_i(6'b101000, rt, ra, $urandom_range(0, 32767));
         3:       return enc_i(6'b101100, rt, ra, $urandom_range(0, 32767));
         4:       return enc_i(6'b101011, rt, ra, $urandom_range(0, 32767));
         5, 6:    return enc_movi(rt, $urandom_range(0, 1048575));
         7:       return enc_i(6'b000010, rt, ra, $urandom_range(0, 32767));
         8:       return enc_i(6'b001010, rt, ra, $urandom_range(0, 32767));
         9:       return enc_mem(rt, ra, rb, $urandom_range(0, 3), 2);
         10:      return enc_mem(rt, ra, rb, $urandom_range(0, 3), 10);
         default: return $urandom;
      endcase
   endfunction

   // Executes one instruction at the architectural level.
   task automatic model_step();
      logic [31:0] w, a, b, t, v;
      logic [4:0]  rt, sh;
      logic        wr;
      int          s15, s20;
      longint      s;
      w   = imem[m_pc[9:2]];
      rt  = w[24:20];
      sh  = w[14:10];
      a   = m_reg[w[19:15]];
      b   = m_reg[w[14:10]];
      t   = m_reg[rt];
      s15 = w[14] ? int'(w[14:0]) - 32768 : int'(w[14:0]);
      s20 = w[19] ? int'(w[19:0]) - 1048576 : int'(w[19:0]);
      wr = 1'b0; v = '0; exp_ld = 1'b0; exp_st = 1'b0; exp_addr = '0; exp_din = '0;
      if (!w[31]) begin
         case (w[30:25])
            6'b100000: begin
               wr = 1'b1;
               case (w[4:0])
                  5'd0: begin
                     v = a + b;
                     s = longint'($signed(a)) + longint'($signed(b));
                     m_ovf = (s != longint'($signed(v)));
                  end
                  5'd1: begin
                     v = a - b;
                     s = longint'($signed(a)) - longint'($signed(b));
                     m_ovf = (s != longint'($signed(v)));
                  end
                  5'd2:  v = a & b;
                  5'd3:  v = a ^ b;
                  5'd4:  v = a | b;
                  5'd8:  v = a << sh;
                  5'd9:  v = a >> sh;
                  5'd11: v = (sh == 0) ? a : ((a >> sh) | (a << (32 - int'(sh))));
                  default: wr = 1'b0;
               endcase
            end
            6'b101000: begin
               wr = 1'b1;
               v  = a + 32'(s15);
               s  = longint'($signed(a)) + longint'(s15);
               m_ovf = (s != longint'($signed(v)));
            end
            6'b101100: begin wr = 1'b1; v = a | {17'b0, w[14:0]}; end
            6'b101011: begin wr = 1'b1; v = a ^ {17'b0, w[14:0]}; end
            6'b100010: begin wr = 1'b1; v = 32'(s20); end
            6'b000010: begin exp_ld = 1'b1; exp_addr = 12'(a + 32'(s15 * 4)); end
            6'b001010: begin exp_st = 1'b1; exp_addr = 12'(a + 32'(s15 * 4)); end
            6'b011100: begin
               exp_addr = 12'(a + (b << w[9:8]));
               exp_ld   = (w[7:0] == 8'h02);
               exp_st   = (w[7:0] == 8'h0A);
            end
            default: ;
         endcase
      end
      if (exp_ld) begin
         wr = 1'b1;
         v  = m_mem[exp_addr[11:2]];
      end
      if (exp_st) begin
         exp_din = t;
         m_mem[exp_addr[11:2]] = t;
      end
      if (!exp_ld && !exp_st) exp_addr = '0;
      if (wr) m_reg[rt] = v;
      m_pc = m_pc + 10'd4;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_reg[i] = '0;
      m_pc  = '0;
      m_ovf = 1'b0;
   endtask

   // Called at the falling edge inside S_IF0.
   task automatic check_state(input int n);
      for (int i = 0; i < 32; i++)
         check($sformatf("r%0d@%0d", i, n), dut.u_rf.regs[i], m_reg[i]);
      check($sformatf("ovf@%0d", n), 32'(alu_overflow), 32'(m_ovf));
      check($sformatf("pc@%0d", n), 32'(IM_address), 32'(m_pc));
      check($sformatf("im_wr@%0d", n), 32'(IM_write), 32'd0);
   endtask

   task automatic run_instr(input int n);
      model_step();
      @(posedge clk); @(negedge clk);
      check($sformatf("im_strobe@%0d", n), 32'({IM_enable, IM_read}), 32'h3);
      repeat (3) begin @(posedge clk); @(negedge clk); end
      check($sformatf("dm_ctl@%0d", n), 32'({DM_enable, DM_read, DM_write}),
            32'({exp_ld | exp_st, exp_ld, exp_st}));
      if (exp_ld || exp_st) check($sformatf("dm_addr@%0d", n), 32'(DM_address), 32'(exp_addr));
      if (exp_st) check($sformatf("dm_in@%0d", n), DM_in, exp_din);
      if (n == 12) check("swi_addr", 32'(DM_address), 32'd4);
      if (n == 16) check("sw_addr", 32'(DM_address), 32'd112);
      repeat (2) begin @(posedge clk); @(negedge clk); end
   endtask

   int          d_n [13] = '{3, 4, 5, 6, 7, 8, 9, 13, 17, 19, 20, 22, 24};
   int          d_r [13] = '{3, 4, 1, 2, 3, 5, 4, 4, 8, 0, 1, 1, 5};
   logic [31:0] d_v [13] = '{32'd16, 32'd14, 32'd27, 32'd12, 32'd36, 32'd2, 32'h9000_0000,
                             32'd12, 32'd12, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFB, 32'd2};

   initial begin
      imem[0]  = enc_movi(0, 9);
      imem[1]  = enc_movi(1, 7);
      imem[2]  = enc_movi(2, 2);
      imem[3]  = enc_alu(3, 0, 1, 0);
      imem[4]  = enc_alu(4, 3, 2, 1);
      imem[5]  = enc_i(6'b101100, 1, 0, 'h12);
      imem[6]  = enc_i(6'b101011, 2, 0, 5);
      imem[7]  = enc_alu(3, 0, 2, 8);
      imem[8]  = enc_alu(5, 0, 2, 9);
      imem[9]  = enc_alu(4, 0, 4, 11);
      imem[10] = enc_movi(2, 12);
      imem[11] = enc_movi(0, 0);
      imem[12] = enc_i(6'b001010, 2, 0, 1);
      imem[13] = enc_i(6'b000010, 4, 0, 1);
      imem[14] = enc_movi(6, 3);
      imem[15] = enc_movi(7, 100);
      imem[16] = enc_mem(2, 7, 6, 2, 'h0A);
      imem[17] = enc_mem(8, 7, 6, 2, 'h02);
      imem[18] = enc_movi(0, -1);
      imem[19] = enc_alu(0, 0, 1, 9);
      imem[20] = enc_i(6'b101000, 1, 0, 1);
      imem[21] = enc_alu(9, 6, 6, 0);
      imem[22] = enc_movi(1, -5);
      imem[23] = {1'b0, 6'b111111, 25'h1AB_CDEF};
      imem[24] = 32'h8000_0000 | enc_movi(5, 77);
      for (int i = 25; i < 256; i++) imem[i] = rand_instr();
      for (int i = 0; i < 1024; i++) m_mem[i] = seed_word(i);
      model_reset();

      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      mem_init = 1'b0;
      rst      = 1'b1;

      check_state(-1);
      check("rst_strobes", 32'({IM_read, IM_enable, DM_read, DM_write, DM_enable}), 32'd0);
      check("rst_dm_in", DM_in, 32'd0);

      for (int n = 0; n < NI; n++) begin
         run_instr(n);
         check_state(n);
         for (int j = 0; j < 13; j++)
            if (d_n[j] == n) check($sformatf("dir_r%0d@%0d", d_r[j], n), dut.u_rf.regs[d_r[j]], d_v[j]);
         if (n == 20) check("ovf_set", 32'(alu_overflow), 32'd1);
         if (n == 21) check("ovf_clr", 32'(alu_overflow), 32'd0);
      end

      // Reset landing in S_MEM of a store must abort it cleanly.
      imem[0] = enc_movi(2, 12);
      imem[1] = enc_i(6'b001010, 2, 0, 1);
      rst = 1'b0;
      @(posedge clk); @(negedge clk);
      rst = 1'b1;
      model_reset();
      check_state(-2);
      run_instr(-2);
      check_state(-3);
      repeat (4) begin @(posedge clk); @(negedge clk); end
      check("mem_store_live", 32'(DM_write), 32'd1);
      rst = 1'b0;
      #1;
      check("rst_dm_write", 32'(DM_write), 32'd0);
      @(posedge clk); @(negedge clk);
      rst = 1'b1;
      model_reset();
      check_state(-4);
      check("rst_no_store", dmem[1], m_mem[1]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tini_cpu_core.md
Name: tini_cpu_core

Overview:
- Multi-cycle 32-bit CPU core executing a subset of the NDS32 (Andes) 32-bit ISA.
- Sits between a word-organised instruction memory and a word-organised data memory, both single-port and clocked on the same clock.
- Contains the PC, a 32x32 register file, an ALU and a fixed six-state control FSM.
- Every instruction takes exactly 6 clock cycles.

Parameters:
- PC_W, 10, instruction byte-address width.
- DA_W, 12, data byte-address width.
- RST_PC, 0, PC value after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- instruction  in  32  instruction word from instruction memory.
- alu_overflow  out  1  signed overflow flag of the last ADD/ADDI/SUB.
- IM_read  out  1  instruction memory read strobe.
- IM_write  out  1  instruction memory write strobe; constant 0.
- IM_enable  out  1  instruction memory enable.
- IM_address  out  10  byte address = PC; the system divides by 4.
- DM_read  out  1  data memory read strobe.
- DM_write  out  1  data memory write strobe.
- DM_enable  out  1  data memory enable.
- DM_address  out  12  byte address; the system divides by 4.
- DM_in  out  32  store data to data memory.
- DM_out  in  32  load data from data memory.

Behaviour:
- Reset (rst==0 at a clk edge):
  - PC=RST_PC; all 32 registers=0; alu_overflow=0.
  - FSM enters S_IF0; all strobes 0; DM_in=0.
- FSM, one state per cycle, cyclic: S_IF0 -> S_IF1 -> S_ID -> S_EX -> S_MEM -> S_WB -> S_IF0.
  - S_IF0, S_IF1: IM_enable=IM_read=1, IM_address=PC.
  - S_ID: latch `instruction` into IR; read ra, rb, and rt (rt is the store source).
  - S_EX: ALU computes its result or the effective address into a register.
  - S_MEM:
    - Loads: DM_enable=DM_read=1.
    - Stores: DM_enable=DM_write=1, DM_in=rt.
    - DM_address = effective address, bits [11:0].
  - S_WB:
    - Write rt with the ALU result, or with DM_out for loads (memory read data is valid in S_WB).
    - PC=PC+4, wrapping mod 2^10.
    - A destination register's new value is visible from the next cycle.
- Encoding:
  - bit31=0; op=[30:25]; rt=[24:20]; ra=[19:15]; rb=[14:10]; imm15=[14:0]; imm5=[14:10]; sub=[4:0]; sv=[9:8]; imm20=[19:0].
- ALU_1 (op 6'b100000), selected by sub:
  - 00000 ADD rt=ra+rb.
  - 00001 SUB rt=ra-rb.
  - 00010 AND.
  - 00011 XOR.
  - 00100 OR.
  - 01000 SLLI rt=ra<<imm5.
  - 01001 SRLI rt=ra>>imm5 (logical).
  - 01011 ROTRI rt=ra rotated right by imm5.
- Immediates:
  - ADDI 101000: rt=ra+sext(imm15).
  - ORI 101100: rt=ra|zext(imm15).
  - XORI 101011: rt=ra^zext(imm15).
  - MOVI 100010: rt=sext(imm20).
- Loads/stores:
  - LWI 000010: rt=M[ra+(sext(imm15)<<2)].
  - SWI 001010: M[ra+(sext(imm15)<<2)]=rt.
  - MEM group 011100, sub[7:0]=0x02 LW: rt=M[ra+(rb<<sv)].
  - MEM group 011100, sub[7:0]=0x0A SW: M[ra+(rb<<sv)]=rt.
- Unknown opcode or sub-op: NOP; still 6 cycles, PC+=4, no register or memory write.
- Register r0 is an ordinary writable register.
- Arithmetic is 32-bit modular.
- alu_overflow:
  - Updated in S_EX only for ADD/ADDI/SUB, set to signed overflow of that op; held otherwise.
  - Overflow does not suppress writeback.
- Rotate by 0 and shift by 0 return ra unchanged.
- Effective address is truncated to 12 bits. Alignment is not checked; memory uses address/4.
- Reset mid-instruction aborts the instruction with no side effects.

Decomposition:
- Shared package:
  - opcode constants OP_ALU1, OP_ADDI, OP_ORI, OP_XORI, OP_MOVI, OP_LWI, OP_SWI, OP_MEM.
  - ALU sub-op constants.
  - FSM state enum.
- One sub-module: tini_regfile (32x32, two async read ports plus a third read for rt, one sync write port, sync active-low clear).
- ALU and controller stay inline.

Test Plan:
- Reset and fetch: hold rst=0 for 1 cycle, release -> IM_address=0, 4, 8 at the start of each successive 6-cycle instruction; IM_write stays 0.
- Immediates: MOVI r0,9; MOVI r1,7; MOVI r2,2; ADD r3,r0,r1; SUB r4,r3,r2 -> r3=16 after cycle 24, r4=14 after cycle 30.
- Logic and shifts:
  - r0=9: ORI r1,r0,0x12 -> 27; XORI r2,r0,5 -> 12.
  - SLLI r3,r0,2 -> 36; SRLI -> 2.
  - ROTRI r4,r0,4 -> 0x90000000.
- Memory:
  - MOVI r2,12; SWI r2,[r0+1] with r0=0 -> DM_write=1 and DM_address=4 in S_MEM, DM_in=12.
  - LWI r4,[r0+1] -> r4=12.
  - SW/LW with rb=3, sv=2 -> address ra+12.
- Overflow:
  - MOVI r0,-1; SRLI r0,r0,1 -> 0x7FFFFFFF.
  - ADDI r1,r0,1 -> r1=0x80000000, alu_overflow=1.
  - Next ADD with no overflow -> alu_overflow=0.
- Negative values and NOP:
  - MOVI r1,-5 -> 0xFFFFFFFB.
  - Undefined opcode -> no register change, PC+4.
  - rst=0 asserted in S_MEM of a store -> no DM write, PC=0.
